// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the icache and dcache
// miss paths, one whole-line transaction at a time.
// Ports: clk/rst; i_pmem_* (icache read side); d_pmem_* (dcache read/write side);
// pmem_* (memory side: registered strobes/address/wdata, rdata/resp inputs).
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } state_t;

    state_t state;
    logic   last_d;   // dcache held the most recent grant
    logic   i_req;
    logic   d_req;
    logic   grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // On a tie the side that did not win last time gets the port.
    assign grant_d = d_req & (~i_req | ~last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last_d       <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_d) begin
                        state        <= SERVE_D;
                        last_d       <= 1'b1;
                        // read+write together is resolved as a write
                        pmem_write   <= d_pmem_write;
                        pmem_read    <= ~d_pmem_write;
                        pmem_address <= d_pmem_address;
                        pmem_wdata   <= d_pmem_write ? d_pmem_wdata : '0;
                    end else if (i_req) begin
                        state        <= SERVE_I;
                        last_d       <= 1'b0;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
                        pmem_address <= i_pmem_address;
                        pmem_wdata   <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state        <= DONE;
                        pmem_read    <= 1'b0;
                        pmem_write   <= 1'b0;
                        pmem_address <= '0;
                        pmem_wdata   <= '0;
                    end
                end
                DONE: begin
                    // bubble so the served cache can drop its request
                    state <= IDLE;
                end
            endcase
        end
    end

    // Completion is routed only to the side currently being served.
    assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
    assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
    assign i_pmem_rdata = i_pmem_resp ? pmem_rdata : '0;
    assign d_pmem_rdata = d_pmem_resp ? pmem_rdata : '0;

    illegal_rw: assert property (
        @(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write)
    );

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: table vectors, hand-written corner sequences and a
// randomized run checked against a transaction-level arbitration model.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int checks = 0;
    int passes = 0;

    cache_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drop_all();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_rdata     = '0;
        pmem_resp      = 1'b0;
    endtask

    typedef struct {
        logic         ir;
        logic         dr;
        logic         dw;
        logic [31:0]  ia;
        logic [31:0]  da;
        logic [255:0] wd;
        logic         exp_d;
        logic         exp_rd;
        logic         exp_wr;
        logic [31:0]  exp_a;
    } vec_t;

    vec_t tbl[8];

    task automatic run_vec(input vec_t v, input int idx);
        logic [255:0] rd;
        @(negedge clk);
        i_pmem_read    = v.ir;
        i_pmem_address = v.ia;
        d_pmem_read    = v.dr;
        d_pmem_write   = v.dw;
        d_pmem_address = v.da;
        d_pmem_wdata   = v.wd;
        @(negedge clk);
        chk($sformatf("vec%0d read", idx), pmem_read, v.exp_rd);
        chk($sformatf("vec%0d write", idx), pmem_write, v.exp_wr);
        chk($sformatf("vec%0d addr", idx), pmem_address, v.exp_a);
        if (v.exp_wr) chk($sformatf("vec%0d wdata", idx), pmem_wdata, v.wd);
        chk($sformatf("vec%0d early resp", idx),
            {i_pmem_resp, d_pmem_resp}, 2'b00);
        i_pmem_address = v.ia ^ 32'h0000_fff0;
        d_pmem_address = v.da ^ 32'h0000_fff0;
        d_pmem_wdata   = ~v.wd;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("vec%0d hold addr", idx), pmem_address, v.exp_a);
            chk($sformatf("vec%0d hold strobe", idx),
                {pmem_read, pmem_write}, {v.exp_rd, v.exp_wr});
            if (v.exp_wr)
                chk($sformatf("vec%0d hold wdata", idx), pmem_wdata, v.wd);
        end
        rd = (idx == 0) ? {32{8'hA5}} : rand_line();
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
        #1;
        chk($sformatf("vec%0d i_resp", idx), i_pmem_resp, !v.exp_d);
        chk($sformatf("vec%0d d_resp", idx), d_pmem_resp, v.exp_d);
        chk($sformatf("vec%0d i_rdata", idx), i_pmem_rdata,
            v.exp_d ? 256'd0 : rd);
        chk($sformatf("vec%0d d_rdata", idx), d_pmem_rdata,
            v.exp_d ? rd : 256'd0);
        @(negedge clk);
        drop_all();
        chk($sformatf("vec%0d done strobe", idx),
            {pmem_read, pmem_write}, 2'b00);
        @(negedge clk);
        chk($sformatf("vec%0d idle addr", idx), pmem_address, 32'd0);
    endtask

    task automatic expect_txn(input string nm, input logic exp_d,
                              input logic exp_wr, input logic [31:0] exp_a,
                              input logic [255:0] exp_wd);
        logic [255:0] rd;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) break;
        end
        chk({nm, " write"}, pmem_write, exp_wr);
        chk({nm, " read"}, pmem_read, !exp_wr);
        chk({nm, " addr"}, pmem_address, exp_a);
        if (exp_wr) chk({nm, " wdata"}, pmem_wdata, exp_wd);
        @(negedge clk);
        chk({nm, " addr held"}, pmem_address, exp_a);
        if (exp_wr) chk({nm, " wdata held"}, pmem_wdata, exp_wd);
        rd         = rand_line();
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
        #1;
        chk({nm, " i_resp"}, i_pmem_resp, !exp_d);
        chk({nm, " d_resp"}, d_pmem_resp, exp_d);
        chk({nm, " rdata"}, exp_d ? d_pmem_rdata : i_pmem_rdata, rd);
        if (exp_d) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end else begin
            i_pmem_read = 1'b0;
        end
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
    endtask

    // random-phase state: cache stimulus and memory/arbitration model
    logic         ip, dp, dw_m;
    logic [31:0]  ia_m, da_m;
    logic [255:0] wd_m;
    int           igap, dgap;
    logic         busy, owner_d, last_owner_d, m_wr, strobe, exp_strobe;
    logic         do_resp, spur;
    logic [31:0]  m_addr;
    logic [255:0] m_wd, rl;
    int           lat, bubble;
    logic         prev_i, prev_d, prev_dw;
    logic [31:0]  prev_ia, prev_da;
    logic [255:0] prev_wd;

    initial begin
        tbl[0] = '{1, 0, 0, 32'h40,  32'h0,   '0, 0, 1, 0, 32'h40};
        tbl[1] = '{1, 1, 0, 32'h100, 32'h200, '0, 1, 1, 0, 32'h200};
        tbl[2] = '{1, 0, 1, 32'h140, 32'h300, {8{32'h1234_5678}},
                   0, 1, 0, 32'h140};
        tbl[3] = '{1, 0, 1, 32'h180, 32'h300, {8{32'h1234_5678}},
                   1, 0, 1, 32'h300};
        tbl[4] = '{0, 1, 0, 32'h0,   32'h400, '0, 1, 1, 0, 32'h400};
        tbl[5] = '{1, 1, 0, 32'h1c0, 32'h440, '0, 0, 1, 0, 32'h1c0};
        tbl[6] = '{0, 0, 1, 32'h0,   32'h480, {8{32'hdead_beef}},
                   1, 0, 1, 32'h480};
        tbl[7] = '{1, 0, 0, 32'h500, 32'h0,   '0, 0, 1, 0, 32'h500};

        drop_all();
        rst = 1'b1;
        #1;
        chk("reset read", pmem_read, 1'b0);
        chk("reset write", pmem_write, 1'b0);
        chk("reset addr", pmem_address, 32'd0);
        chk("reset resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 8; n++) run_vec(tbl[n], n);

        // writeback, then fill, with icache waiting throughout
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h300;
        d_pmem_wdata   = {8{32'h1234_5678}};
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h600;
        expect_txn("seq d-write", 1, 1, 32'h300, {8{32'h1234_5678}});
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h400;
        expect_txn("seq i-read", 0, 0, 32'h600, '0);
        expect_txn("seq d-read", 1, 0, 32'h400, '0);
        repeat (3) @(negedge clk);

        // reset in the middle of a dcache fill
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h700;
        @(negedge clk);
        chk("rst-seq strobe", pmem_read, 1'b1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        #1;
        chk("rst-seq read", pmem_read, 1'b0);
        chk("rst-seq addr", pmem_address, 32'd0);
        chk("rst-seq d_resp", d_pmem_resp, 1'b0);
        chk("rst-seq d_rdata", d_pmem_rdata, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        drop_all();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h800;
        expect_txn("post-rst", 0, 0, 32'h800, '0);
        repeat (3) @(negedge clk);

        // memory response with nothing outstanding
        pmem_resp  = 1'b1;
        pmem_rdata = rand_line();
        #1;
        chk("spur idle resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("spur idle strobe", {pmem_read, pmem_write}, 2'b00);
        @(negedge clk);

        // randomized traffic against the arbitration model
        drop_all();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ip = 0; dp = 0; dw_m = 0; ia_m = 0; da_m = 0; wd_m = 0;
        igap = 0; dgap = 2;
        busy = 0; owner_d = 0; last_owner_d = 0; m_wr = 0;
        m_addr = 0; m_wd = 0; lat = 0; bubble = 0;
        prev_i = 0; prev_d = 0; prev_dw = 0;
        prev_ia = 0; prev_da = 0; prev_wd = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            strobe = pmem_read | pmem_write;
            if (!busy) begin
                exp_strobe = (bubble == 0) && (prev_i || prev_d);
                chk("rnd grant strobe", strobe, exp_strobe);
                if (exp_strobe) begin
                    owner_d      = prev_d && (!prev_i || !last_owner_d);
                    last_owner_d = owner_d;
                    m_addr       = owner_d ? prev_da : prev_ia;
                    m_wr         = owner_d && prev_dw;
                    m_wd         = prev_wd;
                    busy         = 1'b1;
                    lat          = $urandom_range(0, 4);
                end
                if (bubble > 0) bubble--;
            end
            if (busy) begin
                chk("rnd write", pmem_write, m_wr);
                chk("rnd read", pmem_read, !m_wr);
                chk("rnd addr", pmem_address, m_addr);
                if (m_wr) chk("rnd wdata", pmem_wdata, m_wd);
            end
            do_resp = busy && (lat == 0);
            if (busy && lat > 0) lat--;
            spur = !busy && ($urandom_range(0, 5) == 0);
            rl         = rand_line();
            pmem_rdata = rl;
            pmem_resp  = do_resp || spur;
            #1;
            chk("rnd i_resp", i_pmem_resp, do_resp && !owner_d);
            chk("rnd d_resp", d_pmem_resp, do_resp && owner_d);
            chk("rnd i_rdata", i_pmem_rdata,
                (do_resp && !owner_d) ? rl : 256'd0);
            chk("rnd d_rdata", d_pmem_rdata,
                (do_resp && owner_d) ? rl : 256'd0);
            if (do_resp) begin
                busy   = 1'b0;
                bubble = 2;
                if (owner_d) begin
                    dp   = 1'b0;
                    dgap = $urandom_range(1, 4);
                end else begin
                    ip   = 1'b0;
                    igap = $urandom_range(1, 4);
                end
            end
            if (!ip) begin
                if (igap == 0) begin
                    ip   = 1'b1;
                    ia_m = $urandom & 32'hffff_ffe0;
                end else igap--;
            end else if ($urandom_range(0, 3) == 0) begin
                ia_m = $urandom & 32'hffff_ffe0;
            end
            if (!dp) begin
                if (dgap == 0) begin
                    dp   = 1'b1;
                    dw_m = $urandom_range(0, 1) == 1;
                    da_m = $urandom & 32'hffff_ffe0;
                    wd_m = rand_line();
                end else dgap--;
            end else if ($urandom_range(0, 3) == 0) begin
                da_m = $urandom & 32'hffff_ffe0;
                wd_m = rand_line();
            end
            i_pmem_read    = ip;
            i_pmem_address = ia_m;
            d_pmem_read    = dp && !dw_m;
            d_pmem_write   = dp && dw_m;
            d_pmem_address = da_m;
            d_pmem_wdata   = wd_m;
            prev_i  = ip;
            prev_d  = dp;
            prev_dw = dw_m;
            prev_ia = ia_m;
            prev_da = da_m;
            prev_wd = wd_m;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
